// File: rtl/rca_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder sequencer.
package rca_seq_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Width of the slice index counter; kept at least one bit wide.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/rca4_slice.sv
// Purely combinational 4-bit ripple-carry adder built from four chained full adders.
module rca4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[4];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Multi-precision add/subtract sequencer sharing one 4-bit slice across WORDS nibbles.
// Optional subtract support is enabled by defining RCA_SEQ_SUB_EN.
module rca_seq_ctrl
  import rca_seq_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [SLICE_W*WORDS-1:0] a,
  input  logic [SLICE_W*WORDS-1:0] b,
  input  logic                     op,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [SLICE_W*WORDS-1:0] result,
  output logic                     cout,
  output logic                     busy
);

  localparam int unsigned W    = SLICE_W * WORDS;
  localparam int unsigned IdxW = idx_width(WORDS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic [W-1:0]      opa_q;
  logic [W-1:0]      opb_q;
  logic              carry_q;
  logic [W-1:0]      result_q;
  logic              cout_q;
  logic              res_valid_q;
  logic              busy_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] sum_d;
  logic               carry_d;
  logic               sub;

`ifdef RCA_SEQ_SUB_EN
  assign sub = op;
`else
  logic unused_op;
  assign unused_op = op;
  assign sub       = 1'b0;
`endif

  assign slice_a = opa_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_b = opb_q[SLICE_W*idx_q +: SLICE_W];

  rca4_slice u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (sum_d),
    .cout_o (carry_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            opa_q    <= a;
            // Subtract as a + ~b + 1: invert B and seed the carry.
            opb_q    <= sub ? ~b : b;
            carry_q  <= sub;
            result_q <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q[SLICE_W*idx_q +: SLICE_W] <= sum_d;
          carry_q <= carry_d;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            cout_q      <= carry_d;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = res_valid_q;
  assign result      = result_q;
  assign cout        = cout_q;
  assign busy        = busy_q;

endmodule
